sync_filter_bank: RTL and testbench
===================================

// Module: sync_filter_bank
// PURPOSE
//   Parametrised multi-channel synchronizer for async inputs into one clock domain.
//   Per channel: SYNC_STAGES-deep flop chain, stability filter, registered edge pulses.
//   Successor to fixed 2-flop CDC chains: generalises channel count, sync depth and filtering.
//   Sits at the boundary between unclocked top-level ports and clocked logic.
// PARAMETERS
//   NUM_CH        4  number of independent channels (>=1)
//   SYNC_STAGES   2  flops in each synchronizer chain (>=2)
//   FILTER_CYCLES 4  consecutive cycles a new value must persist before acceptance (>=1; 1 = no filtering)
//   RESET_VAL     0  1-bit reset value of sync chain flops and sync_out, common to all channels
// PORTS
//   clk         in   1       single clock; all state on posedge
//   rst         in   1       asynchronous reset, active-high
//   async_in    in   NUM_CH  asynchronous inputs, no timing relation to clk
//   sync_out    out  NUM_CH  synchronized, filtered level per channel (registered)
//   rise_pulse  out  NUM_CH  1-cycle pulse when sync_out[i] goes 0->1 (registered)
//   fall_pulse  out  NUM_CH  1-cycle pulse when sync_out[i] goes 1->0 (registered)
//   changed     out  1       OR of all rise_pulse/fall_pulse bits
// BEHAVIOUR
//   Reset (async, immediate, no clock needed): chain flops=RESET_VAL, sync_out=RESET_VAL,
//     filter counters=0, rise_pulse=fall_pulse=0, changed=0. Held while rst high.
//   Chain: stage[0]<=async_in[i]; stage[k]<=stage[k-1]; s=stage[SYNC_STAGES-1]. No logic between stages.
//   Filter, per channel, counter cnt width $clog2(FILTER_CYCLES):
//     s==sync_out            -> cnt<=0, no update.
//     s!=sync_out, cnt<F-1   -> cnt<=cnt+1.
//     s!=sync_out, cnt==F-1  -> sync_out<=s, cnt<=0, pulse for direction of change.
//     F==1: update on first differing cycle; counter logic optimised away.
//   Glitch: any return of s to sync_out before acceptance clears cnt; counts never resume.
//   Latency: input stable before edge 1 -> sync_out changes at edge SYNC_STAGES+FILTER_CYCLES.
//   Pulses: rise/fall asserted exactly in the cycle sync_out first shows the new value;
//     deasserted next cycle. Never both for one channel in one cycle. Never when s==sync_out.
//   changed: combinational OR of registered pulses; one cycle even if several channels fire together.
//   Channels fully independent; simultaneous events on any subset all reported in the same cycle.
//   Reset mid-filter: partial count discarded; after release full SYNC_STAGES+F latency applies again.
//   Input toggling faster than F cycles: sync_out holds last accepted value indefinitely.
//   Elaboration: SYNC_STAGES<2 or FILTER_CYCLES<1 -> $error.
// STRUCTURE
//   Package sync_filter_pkg: MIN_SYNC_STAGES=2, MIN_FILTER_CYCLES=1,
//     function cnt_width(f) returning max(1,$clog2(f)).
//   Sub-module sync_filter_ch: one channel (chain, filter, pulse regs), params SYNC_STAGES,
//     FILTER_CYCLES, RESET_VAL; ports clk, rst, async_in, sync_out, rise_pulse, fall_pulse.
//   Top: generate loop of NUM_CH sync_filter_ch instances plus changed OR-reduce.
//   Chain flops carry synthesis attribute marking them as synchronizer (no retiming/merging).
// TESTING (NUM_CH=4, SYNC_STAGES=2, FILTER_CYCLES=4, RESET_VAL=0 unless stated)
//   1 Reset: rst=1 between clk edges with outputs nonzero -> all outputs 0 same timestep, no clk edge.
//   2 Rise: async_in=4'b0001 before edge 1, held -> sync_out[0]=1 after edge 6; rise_pulse[0]
//     and changed high for cycle 6->7 only; other channels quiet.
//   3 Glitch: async_in[1] high for 3 cycles then low -> sync_out[1] stays 0, no pulses, ever.
//   4 Simultaneous: ch3 settled at 1; same cycle drive ch2 0->1, ch3 1->0 -> after edge 6
//     rise_pulse=4'b0100, fall_pulse=4'b1000, changed high one cycle.
//   5 Reset mid-filter: ch0 raised, rst pulsed at edge 4 (cnt=1), input held high ->
//     sync_out[0] rises 6 edges after rst release, not earlier.
//   6 Config F=1, SYNC_STAGES=3: async_in[0] 0->1 before edge 1 -> sync_out[0]=1 after edge 4;
//     1->0 before edge 10 -> sync_out[0]=0 after edge 13, fall_pulse[0] one cycle.

Source files
------------

// File: rtl/sync_filter_pkg.sv
// Shared limits and sizing helper for the synchronizer/filter bank.
package sync_filter_pkg;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_FILTER_CYCLES = 1;

    // Filter counter width; never zero so the counter port stays legal when F<=2.
    function automatic int cnt_width(input int f);
        int w;
        w = $clog2(f);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchronizer flop chain, persistence filter and registered edge pulses.
module sync_filter_ch
    import sync_filter_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = cnt_width(FILTER_CYCLES);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
            $error("sync_filter_ch: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
        end
        if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
            $error("sync_filter_ch: FILTER_CYCLES must be >= %0d", MIN_FILTER_CYCLES);
        end
    endgenerate

    // Pure flop chain: tools must not retime, merge or pack these into shift registers.
    (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_touch = "true" *)
    logic [SYNC_STAGES-1:0] r_sync_chain;

    logic r_sync_out;
    logic r_rise;
    logic r_fall;
    logic w_sync_s;
    logic w_differs;
    logic w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign w_sync_s  = r_sync_chain[SYNC_STAGES-1];
    assign w_differs = (w_sync_s != r_sync_out);

    generate
        if (FILTER_CYCLES == 1) begin : g_no_filter
            assign w_accept = w_differs;
        end else begin : g_filter
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
            logic [CW-1:0] r_cnt;

            // Any cycle agreeing with the accepted level restarts the count from zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (!w_differs || (r_cnt == CNT_LAST)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_accept = w_differs && (r_cnt == CNT_LAST);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_out <= RESET_VAL;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_rise <= w_accept &  w_sync_s;
            r_fall <= w_accept & ~w_sync_s;
            if (w_accept) begin
                r_sync_out <= w_sync_s;
            end
        end
    end

    assign sync_out   = r_sync_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronizer/filter channels with an aggregate change flag.
module sync_filter_bank
    import sync_filter_pkg::*;
#(
    parameter int   NUM_CH        = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              changed
);

    generate
        if (NUM_CH < 1) begin : g_bad_num_ch
            $error("sync_filter_bank: NUM_CH must be >= 1");
        end
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
            $error("sync_filter_bank: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            sync_filter_ch #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .RESET_VAL     (RESET_VAL)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .async_in   (async_in[gi]),
                .sync_out   (sync_out[gi]),
                .rise_pulse (rise_pulse[gi]),
                .fall_pulse (fall_pulse[gi])
            );
        end
    endgenerate

    // Pulses are already registered, so this OR adds no extra cycle of latency.
    assign changed = (|rise_pulse) | (|fall_pulse);

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: directed scenarios plus random traffic against a sliding-window model.
module tb_sync_filter_bank;

    localparam int NCH = 4;
    localparam int SA  = 2;
    localparam int FA  = 4;
    localparam int SB  = 3;
    localparam int FB  = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] in_a = '0;
    logic [NCH-1:0] in_b = '0;
    logic [NCH-1:0] sync_a, rise_a, fall_a;
    logic [NCH-1:0] sync_b, rise_b, fall_b;
    logic           chg_a, chg_b;

    int n_checks = 0;
    int n_err    = 0;

    // Model: an output flips once the last F synchronized samples all disagree with it.
    bit             hist_a [NCH][SA+FA];
    bit             hist_b [NCH][SB+FB];
    logic [NCH-1:0] m_out_a, m_rise_a, m_fall_a;
    logic [NCH-1:0] m_out_b, m_rise_b, m_fall_b;

    sync_filter_bank #(.NUM_CH(NCH), .SYNC_STAGES(SA), .FILTER_CYCLES(FA), .RESET_VAL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .async_in(in_a), .sync_out(sync_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .changed(chg_a)
    );

    sync_filter_bank #(.NUM_CH(NCH), .SYNC_STAGES(SB), .FILTER_CYCLES(FB), .RESET_VAL(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .async_in(in_b), .sync_out(sync_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .changed(chg_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < SA+FA; j++) hist_a[c][j] = 1'b0;
            for (int j = 0; j < SB+FB; j++) hist_b[c][j] = 1'b0;
        end
        m_out_a = '0; m_rise_a = '0; m_fall_a = '0;
        m_out_b = '0; m_rise_b = '0; m_fall_b = '0;
    endtask

    task automatic model_edge();
        bit flip;
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < SA+FA-1; j++) hist_a[c][j] = hist_a[c][j+1];
            hist_a[c][SA+FA-1] = in_a[c];
            flip = 1'b1;
            for (int j = 0; j < FA; j++) if (hist_a[c][j] == m_out_a[c]) flip = 1'b0;
            m_rise_a[c] = flip && !m_out_a[c];
            m_fall_a[c] = flip &&  m_out_a[c];
            if (flip) m_out_a[c] = ~m_out_a[c];

            for (int j = 0; j < SB+FB-1; j++) hist_b[c][j] = hist_b[c][j+1];
            hist_b[c][SB+FB-1] = in_b[c];
            flip = 1'b1;
            for (int j = 0; j < FB; j++) if (hist_b[c][j] == m_out_b[c]) flip = 1'b0;
            m_rise_b[c] = flip && !m_out_b[c];
            m_fall_b[c] = flip &&  m_out_b[c];
            if (flip) m_out_b[c] = ~m_out_b[c];
        end
    endtask

    task automatic check_all();
        chk("a_sync_out", sync_a, m_out_a);
        chk("a_rise",     rise_a, m_rise_a);
        chk("a_fall",     fall_a, m_fall_a);
        chk("a_changed",  {3'b000, chg_a}, {3'b000, |{m_rise_a, m_fall_a}});
        chk("b_sync_out", sync_b, m_out_b);
        chk("b_rise",     rise_b, m_rise_b);
        chk("b_fall",     fall_b, m_fall_b);
        chk("b_changed",  {3'b000, chg_b}, {3'b000, |{m_rise_b, m_fall_b}});
    endtask

    // Advance one clock; the model moves only on edges where reset is low.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) model_edge();
        check_all();
    endtask

    // Called at posedge+1: asynchronous reset pulse strictly between clock edges.
    task automatic reset_pulse(input bit check_zero);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        if (check_zero) begin
            chk("rst_async_sync_out", sync_a, 4'b0000);
            chk("rst_async_rise",     rise_a, 4'b0000);
            chk("rst_async_changed",  {3'b000, chg_a}, 4'b0000);
        end
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        step();
        step();
        #2;
        rst = 1'b0;

        // Rise on ch0 (S=2,F=4) and on ch0 of the S=3,F=1 bank.
        in_a = 4'b0001;
        in_b = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) chk("b_before_edge4", sync_b, 4'b0000);
            if (k == 4) begin
                chk("b_sync_edge4", sync_b, 4'b0001);
                chk("b_rise_edge4", rise_b, 4'b0001);
            end
            if (k == 5) chk("a_before_edge6", sync_a, 4'b0000);
        end
        chk("t2_sync_edge6", sync_a, 4'b0001);
        chk("t2_rise_edge6", rise_a, 4'b0001);
        chk("t2_changed",    {3'b000, chg_a}, 4'b0001);

        // Async reset while outputs are nonzero, no clock edge in between.
        reset_pulse(1'b1);

        // Input held high; reset again partway through the filter.
        for (int k = 1; k <= 3; k++) step();
        reset_pulse(1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("t5_not_early", sync_a, 4'b0000);
        end
        chk("t5_sync_after_release", sync_a, 4'b0001);
        step();
        chk("t5_pulse_one_cycle", rise_a, 4'b0000);

        // Glitch on ch1 shorter than the filter window.
        in_a[1] = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        in_a[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t3_glitch_quiet", {1'b0, sync_a[1], rise_a[1], fall_a[1]}, 4'b0000);
        end

        // Simultaneous rise on ch2 and fall on ch3.
        in_a[3] = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        in_a[2] = 1'b1;
        in_a[3] = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        chk("t4_rise", rise_a, 4'b0100);
        chk("t4_fall", fall_a, 4'b1000);
        chk("t4_changed", {3'b000, chg_a}, 4'b0001);
        step();
        chk("t4_changed_drop", {3'b000, chg_a}, 4'b0000);

        // S=3,F=1: rise then fall at fixed edges after a fresh reset.
        in_b = 4'b0000;
        reset_pulse(1'b0);
        in_b[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 4) chk("t6_rise_edge4", sync_b, 4'b0001);
        end
        in_b[0] = 1'b0;
        for (int k = 10; k <= 14; k++) begin
            step();
            if (k == 12) chk("t6_hold_edge12", sync_b, 4'b0001);
            if (k == 13) begin
                chk("t6_fall_edge13", sync_b, 4'b0000);
                chk("t6_fall_pulse",  fall_b, 4'b0001);
            end
            if (k == 14) chk("t6_fall_drop", fall_b, 4'b0000);
        end

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) in_a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) in_b = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) reset_pulse(1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
